muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide, with single-cycle sign preparation and result fix-up around the core loop.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_rs1_data,
  input  logic [XLEN-1:0] MD_rs2_data,
  input  logic            MD_flush,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFixup, StDone} state_e;

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q, rneg_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    sgn_a    = !(funct3_q inside {3'b011, 3'b101, 3'b111});
    sgn_b    = sgn_a && (funct3_q != 3'b010);
    neg_a    = sgn_a & a_q[XLEN-1];
    neg_b    = sgn_b & b_q[XLEN-1];
    abs_a    = neg_a ? -a_q : a_q;
    abs_b    = neg_b ? -b_q : b_q;
    div_zero = funct3_q[2] && (b_q == '0);
    div_ovf  = funct3_q[2] && !funct3_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    if (div_zero) fast_res = funct3_q[1] ? a_q : '1;
    else          fast_res = funct3_q[1] ? '0 : a_q;

    // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
    if (funct3_q[2]) begin
      if (!div_trial[XLEN]) begin
        hi_nx = div_trial[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_nx = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = neg_q ? -lo_q : lo_q;
    rem  = rneg_q ? -hi_q : hi_q;
    case (funct3_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (MD_flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (MD_start) begin
            funct3_q <= MD_funct3;
            a_q      <= MD_rs1_data;
            b_q      <= MD_rs2_data;
            busy_q   <= 1'b1;
            state_q  <= StPrep;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StPrep: begin
          if (div_zero || div_ovf) begin
            result_q <= fast_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            hi_q    <= '0;
            lo_q    <= funct3_q[2] ? abs_a : abs_b;
            opnd_q  <= funct3_q[2] ? abs_b : abs_a;
            neg_q   <= neg_a ^ neg_b;
            rneg_q  <= neg_a;
            cnt_q   <= CntW'(XLEN);
            state_q <= StCalc;
          end
        end
        StCalc: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFixup;
        end
        StFixup: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign MD_busy   = busy_q;
  assign MD_done   = done_q;
  assign MD_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: XLEN=32 and XLEN=16 instances, directed corner cases plus random
// operations checked against a plain-arithmetic reference model, including latency and busy time.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        start32, start16;
  logic        busy32, done32, busy16, done16;
  logic [31:0] res32;
  logic [15:0] res16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) u_md32 (
    .SYS_clk     (clk),
    .SYS_reset   (rst_n),
    .MD_start    (start32),
    .MD_funct3   (f3),
    .MD_rs1_data (rs1),
    .MD_rs2_data (rs2),
    .MD_flush    (flush),
    .MD_busy     (busy32),
    .MD_done     (done32),
    .MD_result   (res32)
  );

  muldiv_unit #(.XLEN(16)) u_md16 (
    .SYS_clk     (clk),
    .SYS_reset   (rst_n),
    .MD_start    (start16),
    .MD_funct3   (f3),
    .MD_rs1_data (rs1[15:0]),
    .MD_rs2_data (rs2[15:0]),
    .MD_flush    (flush),
    .MD_busy     (busy16),
    .MD_done     (done16),
    .MD_result   (res16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: RISC-V M semantics on sign-extended integers, truncated to w bits.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input int w);
    longint      m, au, bu, sa, sb, mn, r;
    logic [63:0] pu;
    m  = (longint'(1) << w) - 1;
    mn = -(longint'(1) << (w - 1));
    au = longint'(a_in) & m;
    bu = longint'(b_in) & m;
    sa = ((au >> (w - 1)) & 1) != 0 ? au - (longint'(1) << w) : au;
    sb = ((bu >> (w - 1)) & 1) != 0 ? bu - (longint'(1) << w) : bu;
    case (f)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * bu) >>> w;
      3'd3: begin pu = au * bu; pu = pu >> w; r = longint'(pu); end
      3'd4: r = (bu == 0) ? -1 : (sa == mn && sb == -1) ? sa : sa / sb;
      3'd5: r = (bu == 0) ? -1 : au / bu;
      3'd6: r = (bu == 0) ? sa : (sa == mn && sb == -1) ? 0 : sa % sb;
      default: r = (bu == 0) ? au : au % bu;
    endcase
    return 32'(r & m);
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int w);
    logic [31:0] m, am, bm;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    am = a_in & m;
    bm = b_in & m;
    return f[2] && (bm == 0 || (!f[0] && am == (32'd1 << (w - 1)) && bm == m));
  endfunction

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << (w - 1);
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; inj>0 pulses a spurious start after that many edges (must be ignored).
  task automatic do_op(input bit s16, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int inj,
                       input string tag);
    int w, n, nb, lat;
    bit seen, d, bz;
    logic [31:0] r;
    w = s16 ? 16 : 32;
    @(negedge clk);
    f3 = f; rs1 = a; rs2 = b;
    if (s16) start16 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start16 = 1'b0;
    n = 1; nb = 0; seen = 1'b0;
    while (!seen && n <= 80) begin
      d  = s16 ? done16 : done32;
      bz = s16 ? busy16 : busy32;
      if (d) begin
        seen = 1'b1;
      end else begin
        if (bz) nb++;
        start32 = 1'b0; start16 = 1'b0;
        if (n == inj) begin
          f3 = 3'b011; rs1 = $urandom; rs2 = $urandom;
          if (s16) start16 = 1'b1; else start32 = 1'b1;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start32 = 1'b0; start16 = 1'b0;
    r   = s16 ? {16'd0, res16} : res32;
    lat = is_fast(f, a, b, w) ? 2 : w + 3;
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_res"}, 64'(r), 64'(exp));
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busy"}, 64'(nb), 64'(lat - 1));
  endtask

  initial begin
    int dn;
    logic [2:0] f;
    logic [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; f3 = '0; rs1 = '0; rs2 = '0;
    start32 = 1'b0; start16 = 1'b0;
    #2;
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_res32", 64'(res32), 64'd0);
    check("rst_res16", 64'(res16), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul7");
    do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
    do_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, "mulhsu");
    do_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh");
    do_op(0, 3'd5, 32'd10, 32'd0, 32'hFFFF_FFFF, 0, "divu0");
    do_op(0, 3'd6, 32'd10, 32'd0, 32'd10, 0, "rem0");
    do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "divovf");
    do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "removf");
    do_op(0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 0, "mulz");
    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10, "divneg");
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "remneg");

    // Flush mid-operation: back to idle, no done, result held.
    @(negedge clk);
    f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start32 = 1'b0;
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_done", 64'(done32), 64'd0);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done32) dn++; end
    check("flush_nodone", 64'(dn), 64'd0);
    check("flush_res", 64'(res32), 64'hFFFF_FFFF);
    @(negedge clk);
    start32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; flush = 1'b0;
    check("flush_over_start", 64'(busy32), 64'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    f3 = 3'd0; rs1 = 32'd5; rs2 = 32'd9; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_done", 64'(done32), 64'd0);
    check("arst_res", 64'(res32), 64'd0);
    dn = 0;
    repeat (5) begin @(posedge clk); #1; if (done32) dn++; end
    check("arst_nodone", 64'(dn), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 0, "post_rst");

    do_op(1, 3'd0, 32'h0000_00FF, 32'h0000_0101, 32'h0000_FFFF, 0, "m16");
    do_op(1, 3'd5, 32'h0000_FFFF, 32'd3, 32'h0000_5555, 0, "b2b16");

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); a = pick(32); b = pick(32);
      do_op(0, f, a, b, ref_md(f, a, b, 32), 0, $sformatf("r32_%0d_f%0d", i, f));
    end
    for (int i = 0; i < 20; i++) begin
      f = 3'($urandom_range(0, 7)); a = pick(16); b = pick(16);
      do_op(1, f, a, b, ref_md(f, a, b, 16), 0, $sformatf("r16_%0d_f%0d", i, f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
